// File: rtl/kbd_pkg.sv
// Shared scan-code constants and state types for the PS/2 key decoder.
// Imported by key_decoder and kbd_idle_timer.
package kbd_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } kbd_st_t;

  typedef enum logic {
    LEFT,
    RIGHT
  } dir_t;

endpackage

// File: rtl/kbd_idle_timer.sv
// Saturating idle counter: cleared by any received byte, done once LIMIT idle cycles pass.
// Used by key_decoder only when KEY_TIMEOUT_EN is defined.
module kbd_idle_timer
  import kbd_pkg::*;
#(
  parameter int LIMIT = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic done
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] r_count;

  // Hold at the limit so done stays asserted until the next byte arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (r_count != LIM) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign done = (r_count == LIM);

endmodule

// File: rtl/key_decoder.sv
// PS/2 set-2 scan-code decoder: held arrow levels with newest-press-wins arbitration,
// one-shot start/shoot pulses. Define KEY_TIMEOUT_EN to release held keys after an idle period.
module key_decoder
  import kbd_pkg::*;
`ifdef KEY_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 50_000_000
)
`endif
(
  input  logic       clk,
  input  logic       reset,
  input  logic       byteValid,
  input  logic [7:0] byteData,
  output logic       leftPress,
  output logic       rightPress,
  output logic       start,
  output logic       shootPulse
);

  kbd_st_t r_state;
  dir_t    r_lastDir;
  logic    r_leftHeld, r_rightHeld, r_enterHeld, r_spaceHeld;
  logic    r_leftPress, r_rightPress, r_start, r_shoot;

  kbd_st_t w_stateNxt;
  dir_t    w_lastDirNxt;
  logic    w_leftNxt, w_rightNxt, w_enterNxt, w_spaceNxt;
  logic    w_startNxt, w_shootNxt;
  logic    w_make, w_ext, w_timeout;

`ifdef KEY_TIMEOUT_EN
  kbd_idle_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_idleTimer (
    .clk  (clk),
    .reset(reset),
    .clear(byteValid),
    .done (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  assign w_make = (r_state == IDLE) || (r_state == EXT);
  assign w_ext  = (r_state == EXT)  || (r_state == EXT_BRK);

  // Next-state decode; a make on an already-held key is a typematic repeat and is silent.
  always_comb begin
    w_stateNxt   = r_state;
    w_lastDirNxt = r_lastDir;
    w_leftNxt    = r_leftHeld;
    w_rightNxt   = r_rightHeld;
    w_enterNxt   = r_enterHeld;
    w_spaceNxt   = r_spaceHeld;
    w_startNxt   = 1'b0;
    w_shootNxt   = 1'b0;

    if (byteValid) begin
      if (byteData == SC_EXT) begin
        w_stateNxt = EXT;
      end else if (byteData == SC_BRK) begin
        case (r_state)
          IDLE:    w_stateNxt = BRK;
          EXT:     w_stateNxt = EXT_BRK;
          default: w_stateNxt = r_state;
        endcase
      end else begin
        w_stateNxt = IDLE;
        if (w_ext && byteData == SC_LEFT) begin
          if (!w_make) begin
            w_leftNxt = 1'b0;
          end else if (!r_leftHeld) begin
            w_leftNxt    = 1'b1;
            w_lastDirNxt = LEFT;
          end
        end else if (w_ext && byteData == SC_RIGHT) begin
          if (!w_make) begin
            w_rightNxt = 1'b0;
          end else if (!r_rightHeld) begin
            w_rightNxt   = 1'b1;
            w_lastDirNxt = RIGHT;
          end
        end else if (!w_ext && byteData == SC_ENTER) begin
          if (!w_make) begin
            w_enterNxt = 1'b0;
          end else if (!r_enterHeld) begin
            w_enterNxt = 1'b1;
            w_startNxt = 1'b1;
          end
        end else if (!w_ext && byteData == SC_SPACE) begin
          if (!w_make) begin
            w_spaceNxt = 1'b0;
          end else if (!r_spaceHeld) begin
            w_spaceNxt = 1'b1;
            w_shootNxt = 1'b1;
          end
        end
      end
    end else if (w_timeout) begin
      // A lost break code would otherwise leave a key stuck down forever.
      w_stateNxt  = IDLE;
      w_leftNxt   = 1'b0;
      w_rightNxt  = 1'b0;
      w_enterNxt  = 1'b0;
      w_spaceNxt  = 1'b0;
    end
  end

  // Single registered FSM; press levels are computed from next-state so they land together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_lastDir    <= LEFT;
      r_leftHeld   <= 1'b0;
      r_rightHeld  <= 1'b0;
      r_enterHeld  <= 1'b0;
      r_spaceHeld  <= 1'b0;
      r_leftPress  <= 1'b0;
      r_rightPress <= 1'b0;
      r_start      <= 1'b0;
      r_shoot      <= 1'b0;
    end else begin
      r_state      <= w_stateNxt;
      r_lastDir    <= w_lastDirNxt;
      r_leftHeld   <= w_leftNxt;
      r_rightHeld  <= w_rightNxt;
      r_enterHeld  <= w_enterNxt;
      r_spaceHeld  <= w_spaceNxt;
      r_leftPress  <= w_leftNxt  & (~w_rightNxt | (w_lastDirNxt == LEFT));
      r_rightPress <= w_rightNxt & (~w_leftNxt  | (w_lastDirNxt == RIGHT));
      r_start      <= w_startNxt;
      r_shoot      <= w_shootNxt;
    end
  end

  assign leftPress  = r_leftPress;
  assign rightPress = r_rightPress;
  assign start      = r_start;
  assign shootPulse = r_shoot;

endmodule

// File: tb/tb_key_decoder.sv
// Directed scoreboard bench for key_decoder; outputs packed as {left,right,start,shoot}.
// Define KEY_TIMEOUT_EN to also exercise the idle release with TIMEOUT_CYCLES=100.
module tb_key_decoder;
  import kbd_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       byteValid = 1'b0;
  logic [7:0] byteData = 8'h00;
  logic       leftPress, rightPress, start, shootPulse;

  int         nTests = 0;
  int         nFail  = 0;
  logic [3:0] expQ[$];
  string      tagQ[$];

`ifdef KEY_TIMEOUT_EN
  key_decoder #(
    .TIMEOUT_CYCLES(100)
  ) dut (
`else
  key_decoder dut (
`endif
    .clk       (clk),
    .reset     (reset),
    .byteValid (byteValid),
    .byteData  (byteData),
    .leftPress (leftPress),
    .rightPress(rightPress),
    .start     (start),
    .shootPulse(shootPulse)
  );

  always #5 clk = ~clk;

  // Pop the oldest expectation and compare against the outputs as seen at this negedge.
  task automatic checkOutput();
    logic [3:0] exp;
    logic [3:0] obs;
    string      tag;
    obs = {leftPress, rightPress, start, shootPulse};
    nTests++;
    if (expQ.size() == 0) begin
      nFail++;
      $error("[TB] FAIL scoreboard_empty: observed %b required an expectation", obs);
    end else begin
      exp = expQ.pop_front();
      tag = tagQ.pop_front();
      assert (obs === exp)
      else begin
        nFail++;
        $error("[TB] FAIL %s: observed %b required %b", tag, obs, exp);
      end
    end
  endtask

  // Drive one byte strobe and queue what the outputs must be on the following cycle.
  task automatic applyStimulus(input logic [7:0] b, input logic [3:0] exp, input string tag);
    @(negedge clk);
    byteValid = 1'b1;
    byteData  = b;
    expQ.push_back(exp);
    tagQ.push_back(tag);
    @(negedge clk);
    byteValid = 1'b0;
    byteData  = 8'h00;
    checkOutput();
  endtask

  task automatic idleCycle(input logic [3:0] exp, input string tag);
    expQ.push_back(exp);
    tagQ.push_back(tag);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic applyReset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    expQ.push_back(4'b0000);
    tagQ.push_back(tag);
    @(negedge clk);
    reset = 1'b0;
    checkOutput();
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idleCycle(4'b0000, "reset_state");

    // right arrow make then break
    applyStimulus(8'hE0, 4'b0000, "t1_e0");
    applyStimulus(8'h74, 4'b0100, "t1_right_make");
    idleCycle(4'b0100, "t1_right_hold");
    applyStimulus(8'hE0, 4'b0100, "t1_brk_e0");
    applyStimulus(8'hF0, 4'b0100, "t1_brk_f0");
    applyStimulus(8'h74, 4'b0000, "t1_right_break");

    // Enter typematic: one pulse per physical press
    applyStimulus(8'h5A, 4'b0010, "t2_start_pulse");
    idleCycle(4'b0000, "t2_pulse_width");
    applyStimulus(8'h5A, 4'b0000, "t2_repeat1");
    applyStimulus(8'h5A, 4'b0000, "t2_repeat2");
    applyStimulus(8'hF0, 4'b0000, "t2_brk_f0");
    applyStimulus(8'h5A, 4'b0000, "t2_enter_break");
    applyStimulus(8'h5A, 4'b0010, "t2_second_pulse");
    idleCycle(4'b0000, "t2_second_width");
    applyStimulus(8'hF0, 4'b0000, "t2_brk2_f0");
    applyStimulus(8'h5A, 4'b0000, "t2_enter_break2");

    // Space pulse and break of an unheld key
    applyStimulus(8'h29, 4'b0001, "space_pulse");
    applyStimulus(8'h29, 4'b0000, "space_repeat");
    applyStimulus(8'hF0, 4'b0000, "space_brk_f0");
    applyStimulus(8'h29, 4'b0000, "space_break");
    applyStimulus(8'hF0, 4'b0000, "unheld_brk_f0");
    applyStimulus(8'h5A, 4'b0000, "unheld_break");

    // Direction arbitration: newest press wins, release hands back
    applyStimulus(8'hE0, 4'b0000, "t3_e0a");
    applyStimulus(8'h6B, 4'b1000, "t3_left_make");
    applyStimulus(8'hE0, 4'b1000, "t3_e0b");
    applyStimulus(8'h74, 4'b0100, "t3_right_wins");
    applyStimulus(8'hE0, 4'b0100, "t3_e0c");
    applyStimulus(8'h6B, 4'b0100, "t3_left_repeat");
    applyStimulus(8'hE0, 4'b0100, "t3_brk_e0");
    applyStimulus(8'hF0, 4'b0100, "t3_brk_f0");
    applyStimulus(8'h74, 4'b1000, "t3_handback_left");
    applyStimulus(8'hE0, 4'b1000, "t3_rel_e0");
    applyStimulus(8'hF0, 4'b1000, "t3_rel_f0");
    applyStimulus(8'h6B, 4'b0000, "t3_left_break");

    // Ignored codes
    applyStimulus(8'h6B, 4'b0000, "t4_keypad4");
    applyStimulus(8'hE1, 4'b0000, "t4_e1");
    applyStimulus(8'h14, 4'b0000, "t4_14");
    applyStimulus(8'h77, 4'b0000, "t4_77");
    applyStimulus(8'hAA, 4'b0000, "t4_aa");
    applyStimulus(8'hE0, 4'b0000, "t4_fake_e0");
    applyStimulus(8'h12, 4'b0000, "t4_fake_shift");
    applyStimulus(8'hE0, 4'b0000, "t4_e0");
    applyStimulus(8'h6B, 4'b1000, "t4_left_after");

    // Reset behaviour
    applyReset("t5_reset_held");
    applyStimulus(8'hE0, 4'b0000, "t5_prefix");
    applyReset("t5_reset_prefix");
    applyStimulus(8'h6B, 4'b0000, "t5_prefix_dropped");

`ifdef KEY_TIMEOUT_EN
    applyStimulus(8'hE0, 4'b0000, "t6_e0");
    applyStimulus(8'h6B, 4'b1000, "t6_left_make");
    repeat (98) @(negedge clk);
    idleCycle(4'b1000, "t6_before_timeout");
    repeat (3) @(negedge clk);
    idleCycle(4'b0000, "t6_timed_out");
    applyStimulus(8'hE0, 4'b0000, "t6b_e0");
    applyStimulus(8'h6B, 4'b1000, "t6b_left_make");
    repeat (97) @(negedge clk);
    applyStimulus(8'hAA, 4'b1000, "t6b_byte_at_99");
    repeat (60) @(negedge clk);
    idleCycle(4'b1000, "t6b_still_held");
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
